axis_cabs_deserial: RTL and testbench

- Reader for the packed "data + magnitude" AXI-Stream bus produced by the peak-path complex-abs stage.
- Accepts one wide beat holding NUM_CHANNELS complex samples plus NUM_CHANNELS magnitudes.
- Emits NUM_CHANNELS narrow beats in order, channel 0 first. Each narrow beat carries one sample, its magnitude, its channel index, and tlast on the final channel.
- Feeds the per-channel peak search and threshold logic, which consumes one channel per cycle.

---
 rtl/axis_cabs_deserial.sv | 107 ++++++++++
 tb/tb_axis_cabs_deserial.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_cabs_deserial.sv
// ---------------------------------------------------------------------------
// axis_cabs_deserial
// Splits one wide AXI-Stream beat carrying NUM_CHANNELS complex samples plus
// their NUM_CHANNELS magnitudes into NUM_CHANNELS narrow beats, channel 0 first.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   s_axis_tvalid/tready: wide-beat handshake
//   s_axis_tdata        : packed samples, channel n at [n*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//   s_axis_tdata_abs    : packed magnitudes, same packing
//   m_axis_tvalid/tready: narrow-beat handshake
//   m_axis_tdata        : sample of the current channel
//   m_axis_tdata_abs    : magnitude of the current channel
//   m_axis_tuser        : channel index 0..NUM_CHANNELS-1
//   m_axis_tlast        : high on the final channel of a wide beat
// ---------------------------------------------------------------------------
module axis_cabs_deserial #(
  parameter int  NUM_CHANNELS  = 4,
  parameter int  CHANNEL_WIDTH = 64,
  localparam int COUNT_WIDTH   = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1,
  localparam int DATA_WIDTH    = CHANNEL_WIDTH * NUM_CHANNELS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata_abs,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [CHANNEL_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNEL_WIDTH-1:0] m_axis_tdata_abs,
  output logic [COUNT_WIDTH-1:0]   m_axis_tuser,
  output logic                     m_axis_tlast
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [COUNT_WIDTH-1:0] IDX_ONE  = COUNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  data_buf_q, data_buf_d;
  logic [DATA_WIDTH-1:0]  abs_buf_q,  abs_buf_d;
  logic                   full_q,     full_d;
  logic [COUNT_WIDTH-1:0] idx_q,      idx_d;

  logic last_s;
  logic m_frame_s;
  logic s_frame_s;

  logic [CHANNEL_WIDTH-1:0] data_ch_s [NUM_CHANNELS];
  logic [CHANNEL_WIDTH-1:0] abs_ch_s  [NUM_CHANNELS];

  assign last_s    = (idx_q == LAST_IDX);
  // m_axis_tvalid is full_q, so the narrow handshake needs no output feedback.
  assign m_frame_s = full_q & m_axis_tready;
  // Accepting while the last channel leaves keeps the output stream gapless.
  assign s_axis_tready = ~full_q | (m_frame_s & last_s);
  assign s_frame_s     = s_axis_tvalid & s_axis_tready;

  // Next-state: a load takes priority over retiring the last channel.
  always_comb begin
    data_buf_d = data_buf_q;
    abs_buf_d  = abs_buf_q;
    full_d     = full_q;
    idx_d      = idx_q;
    if (s_frame_s) begin
      data_buf_d = s_axis_tdata;
      abs_buf_d  = s_axis_tdata_abs;
      full_d     = 1'b1;
      idx_d      = {COUNT_WIDTH{1'b0}};
    end else if (m_frame_s && last_s) begin
      full_d = 1'b0;
      idx_d  = {COUNT_WIDTH{1'b0}};
    end else if (m_frame_s) begin
      idx_d = idx_q + IDX_ONE;
    end else begin
      idx_d = idx_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_buf_q <= {DATA_WIDTH{1'b0}};
      abs_buf_q  <= {DATA_WIDTH{1'b0}};
      full_q     <= 1'b0;
      idx_q      <= {COUNT_WIDTH{1'b0}};
    end else begin
      data_buf_q <= data_buf_d;
      abs_buf_q  <= abs_buf_d;
      full_q     <= full_d;
      idx_q      <= idx_d;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_slice
    assign data_ch_s[g] = data_buf_q[g*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    assign abs_ch_s[g]  = abs_buf_q[g*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  end

  // Outputs are muxes of registers only; nothing from s_* reaches m_* directly.
  assign m_axis_tvalid    = full_q;
  assign m_axis_tdata     = data_ch_s[idx_q];
  assign m_axis_tdata_abs = abs_ch_s[idx_q];
  assign m_axis_tuser     = idx_q;
  assign m_axis_tlast     = full_q & last_s;

endmodule

// File: tb/tb_axis_cabs_deserial.sv
module tb_axis_cabs_deserial;

  localparam int CW = 64;
  localparam int N4 = 4;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-channel instance
  logic            s4_valid, s4_ready, m4_valid, m4_ready, m4_last;
  logic [CW*N4-1:0] s4_data, s4_abs;
  logic [CW-1:0]   m4_data, m4_abs;
  logic [1:0]      m4_user;

  // 3-channel instance
  logic            s3_valid, s3_ready, m3_valid, m3_ready, m3_last;
  logic [CW*N3-1:0] s3_data, s3_abs;
  logic [CW-1:0]   m3_data, m3_abs;
  logic [1:0]      m3_user;

  int vectors    = 0;
  int miscompares = 0;

  axis_cabs_deserial #(.NUM_CHANNELS(N4), .CHANNEL_WIDTH(CW)) dut4 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s4_valid), .s_axis_tready(s4_ready),
    .s_axis_tdata(s4_data), .s_axis_tdata_abs(s4_abs),
    .m_axis_tvalid(m4_valid), .m_axis_tready(m4_ready),
    .m_axis_tdata(m4_data), .m_axis_tdata_abs(m4_abs),
    .m_axis_tuser(m4_user), .m_axis_tlast(m4_last)
  );

  axis_cabs_deserial #(.NUM_CHANNELS(N3), .CHANNEL_WIDTH(CW)) dut3 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s3_valid), .s_axis_tready(s3_ready),
    .s_axis_tdata(s3_data), .s_axis_tdata_abs(s3_abs),
    .m_axis_tvalid(m3_valid), .m_axis_tready(m3_ready),
    .m_axis_tdata(m3_data), .m_axis_tdata_abs(m3_abs),
    .m_axis_tuser(m3_user), .m_axis_tlast(m3_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW*N4-1:0] mk4(input logic [63:0] base);
    logic [CW*N4-1:0] r;
    for (int c = 0; c < N4; c++) r[c*CW +: CW] = base + 64'(c);
    return r;
  endfunction

  function automatic logic [CW*N3-1:0] mk3(input logic [63:0] base);
    logic [CW*N3-1:0] r;
    for (int c = 0; c < N3; c++) r[c*CW +: CW] = base + 64'(c);
    return r;
  endfunction

  // Reference model: each accepted wide beat becomes a queue of pending
  // narrow beats; the head of the queue is what the output must show.
  logic [63:0] q4d[$], q4a[$], q3d[$], q3a[$];
  int          q4u[$], q3u[$];
  logic [63:0] h4d = 64'h0, h4a = 64'h0, h3d = 64'h0, h3a = 64'h0;

  always @(negedge clk) begin : model_cmp
    bit e_sr4, e_sr3;
    if (rst) begin
      q4d.delete(); q4a.delete(); q4u.delete();
      q3d.delete(); q3a.delete(); q3u.delete();
      h4d = 64'h0; h4a = 64'h0; h3d = 64'h0; h3a = 64'h0;
    end
    e_sr4 = (q4u.size() == 0) || (q4u.size() == 1 && m4_ready);
    e_sr3 = (q3u.size() == 0) || (q3u.size() == 1 && m3_ready);
    chk("m4_s_tready", 64'(s4_ready), 64'(e_sr4));
    chk("m3_s_tready", 64'(s3_ready), 64'(e_sr3));
    if (q4u.size() > 0) begin
      chk("m4_tvalid", 64'(m4_valid), 64'h1);
      chk("m4_tdata", m4_data, q4d[0]);
      chk("m4_tabs", m4_abs, q4a[0]);
      chk("m4_tuser", 64'(m4_user), 64'(q4u[0]));
      chk("m4_tlast", 64'(m4_last), 64'(q4u[0] == N4 - 1));
    end else begin
      chk("m4_tvalid", 64'(m4_valid), 64'h0);
      chk("m4_tdata", m4_data, h4d);
      chk("m4_tabs", m4_abs, h4a);
      chk("m4_tuser", 64'(m4_user), 64'h0);
      chk("m4_tlast", 64'(m4_last), 64'h0);
    end
    if (q3u.size() > 0) begin
      chk("m3_tvalid", 64'(m3_valid), 64'h1);
      chk("m3_tdata", m3_data, q3d[0]);
      chk("m3_tabs", m3_abs, q3a[0]);
      chk("m3_tuser", 64'(m3_user), 64'(q3u[0]));
      chk("m3_tlast", 64'(m3_last), 64'(q3u[0] == N3 - 1));
    end else begin
      chk("m3_tvalid", 64'(m3_valid), 64'h0);
      chk("m3_tdata", m3_data, h3d);
      chk("m3_tabs", m3_abs, h3a);
      chk("m3_tuser", 64'(m3_user), 64'h0);
      chk("m3_tlast", 64'(m3_last), 64'h0);
    end
    if (!rst) begin
      if (q4u.size() > 0 && m4_ready) begin
        void'(q4d.pop_front()); void'(q4a.pop_front()); void'(q4u.pop_front());
      end
      if (s4_valid && e_sr4) begin
        for (int c = 0; c < N4; c++) begin
          q4d.push_back(s4_data[c*CW +: CW]);
          q4a.push_back(s4_abs[c*CW +: CW]);
          q4u.push_back(c);
        end
        h4d = s4_data[CW-1:0];
        h4a = s4_abs[CW-1:0];
      end
      if (q3u.size() > 0 && m3_ready) begin
        void'(q3d.pop_front()); void'(q3a.pop_front()); void'(q3u.pop_front());
      end
      if (s3_valid && e_sr3) begin
        for (int c = 0; c < N3; c++) begin
          q3d.push_back(s3_data[c*CW +: CW]);
          q3a.push_back(s3_abs[c*CW +: CW]);
          q3u.push_back(c);
        end
        h3d = s3_data[CW-1:0];
        h3a = s3_abs[CW-1:0];
      end
    end
  end

  initial begin : stim
    int          n_last, exp_u, b3, nb3, nl3, bad3;
    bit          acc;
    logic [15:0] rp;

    rst = 1'b1;
    s4_valid = 1'b0; m4_ready = 1'b0; s4_data = '0; s4_abs = '0;
    s3_valid = 1'b0; m3_ready = 1'b0; s3_data = '0; s3_abs = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_tvalid", 64'(m4_valid), 64'h0);
    chk("rst_tuser", 64'(m4_user), 64'h0);
    chk("rst_tlast", 64'(m4_last), 64'h0);
    chk("rst_tdata", m4_data, 64'h0);
    chk("rst_tabs", m4_abs, 64'h0);
    rst = 1'b0;
    tick();
    chk("rst_s_tready", 64'(s4_ready), 64'h1);

    // Single beat with hand-computed channel values
    m4_ready = 1'b1;
    s4_valid = 1'b1;
    s4_data  = mk4(64'h1000_0000_0000_0000);
    s4_abs   = mk4(64'h0000_0000_0000_00A0);
    tick();
    s4_valid = 1'b0;
    for (int c = 0; c < N4; c++) begin
      chk("t1_tvalid", 64'(m4_valid), 64'h1);
      chk("t1_tuser", 64'(m4_user), 64'(c));
      chk("t1_tdata", m4_data, 64'h1000_0000_0000_0000 + 64'(c));
      chk("t1_tabs", m4_abs, 64'h0000_0000_0000_00A0 + 64'(c));
      chk("t1_tlast", 64'(m4_last), 64'(c == 3));
      chk("t1_s_tready", 64'(s4_ready), 64'(c == 3));
      tick();
    end
    // Upstream idle: valid drops, inputs ignored, buffer held
    for (int i = 0; i < 3; i++) begin
      s4_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      s4_abs  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      chk("t6_tvalid", 64'(m4_valid), 64'h0);
      chk("t6_s_tready", 64'(s4_ready), 64'h1);
      chk("t6_tdata", m4_data, 64'h1000_0000_0000_0000);
      chk("t6_tabs", m4_abs, 64'h0000_0000_0000_00A0);
      tick();
    end

    // Back-to-back wide beats
    s4_valid = 1'b1;
    s4_data = mk4(64'h2000_0000_0000_0000); s4_abs = mk4(64'h0000_0000_0000_0B00);
    tick();
    s4_data = mk4(64'h2000_0000_0000_0010); s4_abs = mk4(64'h0000_0000_0000_0B10);
    n_last = 0;
    for (int i = 0; i < 12; i++) begin
      chk("t2_tvalid", 64'(m4_valid), 64'h1);
      chk("t2_tuser", 64'(m4_user), 64'(i % 4));
      if (m4_last) n_last++;
      tick();
      if (i == 3) begin
        s4_data = mk4(64'h2000_0000_0000_0020); s4_abs = mk4(64'h0000_0000_0000_0B20);
      end
      if (i == 7) s4_valid = 1'b0;
    end
    chk("t2_tlast_count", 64'(n_last), 64'd3);
    chk("t2_drained", 64'(m4_valid), 64'h0);

    // Backpressure with a waiting next beat
    s4_valid = 1'b1;
    s4_data = mk4(64'h3000_0000_0000_0000); s4_abs = mk4(64'h0000_0000_0000_00C0);
    tick();
    s4_data = mk4(64'h3100_0000_0000_0000); s4_abs = mk4(64'h0000_0000_0000_00D0);
    rp = 16'b1111_1111_0110_1001;
    exp_u = 0;
    for (int i = 0; i < 40 && exp_u < 4; i++) begin
      m4_ready = rp[i % 16];
      #1;
      if (m4_valid && m4_ready) begin
        chk("t3_order", 64'(m4_user), 64'(exp_u));
        chk("t3_tdata", m4_data, 64'h3000_0000_0000_0000 + 64'(exp_u));
        exp_u++;
      end else begin
        chk("t3_s_tready", 64'(s4_ready), 64'h0);
      end
      tick();
    end
    chk("t3_handoffs", 64'(exp_u), 64'd4);
    chk("t3_reload_tuser", 64'(m4_user), 64'h0);
    chk("t3_reload_tdata", m4_data, 64'h3100_0000_0000_0000);
    s4_valid = 1'b0;
    m4_ready = 1'b1;
    repeat (4) tick();
    chk("t3_drained", 64'(m4_valid), 64'h0);

    // Asynchronous reset after channel 1 hand-off
    s4_valid = 1'b1;
    s4_data = mk4(64'h4000_0000_0000_0000); s4_abs = mk4(64'h0000_0000_0000_00E0);
    tick();
    s4_valid = 1'b0;
    tick();
    tick();
    chk("t4_pre_tuser", 64'(m4_user), 64'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_async_tvalid", 64'(m4_valid), 64'h0);
    chk("t4_async_tuser", 64'(m4_user), 64'h0);
    chk("t4_async_tlast", 64'(m4_last), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t4_s_tready", 64'(s4_ready), 64'h1);
    s4_valid = 1'b1;
    s4_data = mk4(64'h5000_0000_0000_0000); s4_abs = mk4(64'h0000_0000_0000_00F0);
    tick();
    s4_valid = 1'b0;
    chk("t4_restart_tuser", 64'(m4_user), 64'h0);
    chk("t4_restart_tdata", m4_data, 64'h5000_0000_0000_0000);
    repeat (4) tick();

    // Three-channel instance, five streamed beats
    m3_ready = 1'b1;
    b3 = 0; nb3 = 0; nl3 = 0; bad3 = 0;
    s3_valid = 1'b1;
    s3_data = mk3(64'h6000_0000_0000_0000); s3_abs = mk3(64'h0000_0000_0000_0100);
    for (int cyc = 0; cyc < 60 && !(b3 >= 5 && !m3_valid); cyc++) begin
      acc = s3_valid && s3_ready;
      tick();
      if (acc) begin
        b3++;
        if (b3 < 5) begin
          s3_data = mk3(64'h6000_0000_0000_0000 + 64'(b3 * 256));
          s3_abs  = mk3(64'h0000_0000_0000_0100 + 64'(b3 * 16));
        end else begin
          s3_valid = 1'b0;
        end
      end
      if (m3_valid) begin
        nb3++;
        if (m3_user > 2'd2) bad3++;
        if (m3_last != (m3_user == 2'd2)) bad3++;
        if (m3_last) nl3++;
      end
    end
    chk("t5_accepted", 64'(b3), 64'd5);
    chk("t5_beats", 64'(nb3), 64'd15);
    chk("t5_tlast_count", 64'(nl3), 64'd5);
    chk("t5_bad_user", 64'(bad3), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
